// File: rtl/cache_arbiter_pkg.sv
// Shared types and sizing for the I/D cache physical-memory arbiter.
package cache_arbiter_pkg;

  localparam int unsigned ARB_LINE_WIDTH   = 256;
  localparam int unsigned ARB_ADDR_WIDTH   = 32;
  localparam int unsigned LINE_OFFSET_BITS = $clog2(ARB_LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I,
    ARB_D
  } arb_state_t;

  typedef enum logic {
    ARB_CLIENT_I,
    ARB_CLIENT_D
  } arb_client_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache; the winner's
// request is latched at grant and the response is routed back only to it.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = ARB_LINE_WIDTH,
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned D_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  i_pmem_read,
  input  logic                  i_pmem_write,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

  arb_state_t  state;
  arb_client_t rr_next;

  logic                  i_req;
  logic                  d_req;
  logic                  grant_d;
  logic                  sel_read;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;

  // Grant selection: D wins when alone, on priority mode, or when it holds the round-robin turn.
  assign i_req   = i_pmem_read | i_pmem_write;
  assign d_req   = d_pmem_read | d_pmem_write;
  assign grant_d = d_req && (!i_req || (D_PRIORITY != 0) || (rr_next == ARB_CLIENT_D));

  // Write takes precedence over read when a client illegally raises both.
  assign sel_write = grant_d ? d_pmem_write : i_pmem_write;
  assign sel_read  = grant_d ? (d_pmem_read & ~d_pmem_write) : (i_pmem_read & ~i_pmem_write);
  assign sel_addr  = grant_d ? d_pmem_address : i_pmem_address;
  assign sel_wdata = grant_d ? d_pmem_wdata : i_pmem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      rr_next      <= ARB_CLIENT_I;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_req || d_req) begin
            state        <= grant_d ? ARB_D : ARB_I;
            pmem_read    <= sel_read;
            pmem_write   <= sel_write;
            pmem_address <= sel_addr & ADDR_MASK;
            pmem_wdata   <= sel_wdata;
            if (i_req && d_req && (D_PRIORITY == 0)) begin
              rr_next <= grant_d ? ARB_CLIENT_I : ARB_CLIENT_D;
            end
          end
        end
        ARB_I, ARB_D: begin
          if (pmem_resp) begin
            state      <= ARB_IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Data is broadcast; only the completion strobe is steered to the owner.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = pmem_resp && (state == ARB_I);
  assign d_pmem_resp  = pmem_resp && (state == ARB_D);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && (state == ARB_IDLE)) begin
      assert (!(i_pmem_read && i_pmem_write));
      assert (!(d_pmem_read && d_pmem_write));
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: round-robin instance (dut0) and D-priority instance (dut1).
module tb_cache_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  logic          i_resp0, d_resp0, rd0, wr0;
  logic [LW-1:0] i_rdata0, d_rdata0, wdata0;
  logic [AW-1:0] addr0;
  logic          i_resp1, d_resp1, rd1, wr1;
  logic [LW-1:0] i_rdata1, d_rdata1, wdata1;
  logic [AW-1:0] addr1;

  int tests_run = 0;
  int tests_failed = 0;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .D_PRIORITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_read), .i_pmem_write(i_write), .i_pmem_address(i_addr),
    .i_pmem_wdata(i_wdata), .i_pmem_resp(i_resp0), .i_pmem_rdata(i_rdata0),
    .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
    .d_pmem_wdata(d_wdata), .d_pmem_resp(d_resp0), .d_pmem_rdata(d_rdata0),
    .pmem_read(rd0), .pmem_write(wr0), .pmem_address(addr0), .pmem_wdata(wdata0),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .D_PRIORITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_read), .i_pmem_write(i_write), .i_pmem_address(i_addr),
    .i_pmem_wdata(i_wdata), .i_pmem_resp(i_resp1), .i_pmem_rdata(i_rdata1),
    .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
    .d_pmem_wdata(d_wdata), .d_pmem_resp(d_resp1), .d_pmem_rdata(d_rdata1),
    .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1), .pmem_wdata(wdata1),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // Raise pmem_resp for the current cycle and let combinational outputs settle.
  task automatic respond(input logic [LW-1:0] data);
    pmem_resp  = 1;
    pmem_rdata = data;
    #1;
  endtask

  logic [LW-1:0] a5_line, beef_line, c3_line;

  initial begin
    a5_line   = {32{8'hA5}};
    beef_line = {8{32'hDEADBEEF}};
    c3_line   = {32{8'h3C}};
    rst_n = 1;
    idle_inputs();
    #2;
    do_reset();

    // Reset state
    check("rst_read",  LW'(rd0), '0);
    check("rst_write", LW'(wr0), '0);
    check("rst_addr",  LW'(addr0), '0);
    check("rst_wdata", wdata0, '0);
    check("rst_iresp", LW'(i_resp0), '0);
    check("rst_dresp", LW'(d_resp0), '0);

    // Lone I read
    i_read = 1; i_addr = 32'h0000_1234;
    step();
    i_read = 0;
    check("iread_rd",   LW'(rd0), LW'(1));
    check("iread_wr",   LW'(wr0), '0);
    check("iread_addr", LW'(addr0), LW'(32'h0000_1220));
    step();
    respond(a5_line);
    check("iread_iresp",  LW'(i_resp0), LW'(1));
    check("iread_irdata", i_rdata0, a5_line);
    check("iread_dresp",  LW'(d_resp0), '0);
    check("iread_drdata", d_rdata0, a5_line);
    step();
    pmem_resp = 0;
    #1;
    check("iread_iresp_off", LW'(i_resp0), '0);
    check("iread_rd_off",    LW'(rd0), '0);

    // Round-robin tie after reset: I first, then D
    do_reset();
    i_read = 1; i_addr = 32'h0000_0100;
    d_read = 1; d_addr = 32'h0000_2040;
    step();
    check("rr1_addr_i", LW'(addr0), LW'(32'h0000_0100));
    check("rr1_rd",     LW'(rd0), LW'(1));
    respond(c3_line);
    check("rr1_iresp", LW'(i_resp0), LW'(1));
    check("rr1_dresp", LW'(d_resp0), '0);
    step();
    pmem_resp = 0; i_read = 0;
    check("rr1_turn_rd", LW'(rd0), '0);
    step();
    check("rr1_addr_d", LW'(addr0), LW'(32'h0000_2040));
    check("rr1_rd_d",   LW'(rd0), LW'(1));
    respond(c3_line);
    check("rr1_dresp2", LW'(d_resp0), LW'(1));
    check("rr1_iresp2", LW'(i_resp0), '0);
    step();
    pmem_resp = 0; d_read = 0;

    // Second tie: D holds the turn now
    i_read = 1; i_addr = 32'h0000_4000;
    d_read = 1; d_addr = 32'h0000_3000;
    step();
    check("rr2_addr_d", LW'(addr0), LW'(32'h0000_3000));
    respond(a5_line);
    check("rr2_dresp", LW'(d_resp0), LW'(1));
    check("rr2_iresp", LW'(i_resp0), '0);
    step();
    pmem_resp = 0; d_read = 0;
    step();
    check("rr2_addr_i", LW'(addr0), LW'(32'h0000_4000));
    respond(a5_line);
    check("rr2_iresp2", LW'(i_resp0), LW'(1));
    step();
    pmem_resp = 0; i_read = 0;

    // D priority: four back-to-back D grants while I waits
    do_reset();
    i_read = 1; i_addr = 32'h0000_5000;
    d_read = 1; d_addr = 32'h0001_0000;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("dpri_addr_%0d", k), LW'(addr1), LW'(32'h0001_0000 + 32'(k) * 32'h40));
      respond(a5_line);
      check($sformatf("dpri_dresp_%0d", k), LW'(d_resp1), LW'(1));
      check($sformatf("dpri_iresp_%0d", k), LW'(i_resp1), '0);
      step();
      pmem_resp = 0;
      d_addr = 32'h0001_0000 + 32'(k + 1) * 32'h40;
      if (k == 3) d_read = 0;
    end
    step();
    check("dpri_addr_i", LW'(addr1), LW'(32'h0000_5000));
    respond(a5_line);
    check("dpri_iresp_last", LW'(i_resp1), LW'(1));
    step();
    pmem_resp = 0; i_read = 0;

    // D write: latched values hold while D inputs change
    do_reset();
    d_write = 1; d_addr = 32'h8000_0047; d_wdata = beef_line;
    step();
    check("dwr_wr",    LW'(wr0), LW'(1));
    check("dwr_rd",    LW'(rd0), '0);
    check("dwr_addr",  LW'(addr0), LW'(32'h8000_0040));
    check("dwr_wdata", wdata0, beef_line);
    d_write = 0; d_read = 1; d_addr = 32'hFFFF_FFFF; d_wdata = '0;
    step();
    check("dwr_hold_addr",  LW'(addr0), LW'(32'h8000_0040));
    check("dwr_hold_wdata", wdata0, beef_line);
    check("dwr_hold_wr",    LW'(wr0), LW'(1));
    step();
    respond('0);
    check("dwr_dresp", LW'(d_resp0), LW'(1));
    check("dwr_resp_wdata", wdata0, beef_line);
    step();
    pmem_resp = 0; d_read = 0;

    // Asynchronous reset during ARB_D, then a stray response
    do_reset();
    d_read = 1; d_addr = 32'h0000_9000;
    step();
    d_read = 0;
    check("arst_pre_rd", LW'(rd0), LW'(1));
    #2;
    rst_n = 0;
    #1;
    check("arst_rd",   LW'(rd0), '0);
    check("arst_addr", LW'(addr0), '0);
    step();
    rst_n = 1;
    respond(a5_line);
    check("arst_stray_dresp", LW'(d_resp0), '0);
    check("arst_stray_iresp", LW'(i_resp0), '0);
    step();
    pmem_resp = 0;

    // pmem_resp while idle: no effect, next request still 1-cycle latency
    respond(a5_line);
    check("idle_resp_i", LW'(i_resp0), '0);
    check("idle_resp_d", LW'(d_resp0), '0);
    step();
    pmem_resp = 0;
    check("idle_resp_rd", LW'(rd0), '0);
    i_read = 1; i_addr = 32'h0000_0040;
    step();
    i_read = 0;
    check("idle_after_rd",   LW'(rd0), LW'(1));
    check("idle_after_addr", LW'(addr0), LW'(32'h0000_0040));
    respond(c3_line);
    check("idle_after_iresp", LW'(i_resp0), LW'(1));
    step();
    pmem_resp = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
